// File: rtl/rx_nrzi_unstuff.sv
// rtl/rx_nrzi_unstuff.sv - USB RX NRZI decoder with bit-unstuffing and LSB-first byte assembly
// Decodes one D+ sample per strobe, drops stuff bits and flags stuffing and alignment errors.
module rx_nrzi_unstuff #(
  parameter int   STUFF_LEN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_d_plus_sync,
  input  logic       i_shift_enable,
  input  logic       i_rcv_active,
  input  logic       i_eop_detected,
  output logic       o_d_orig,
  output logic       o_invalid_bit,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_stuff_error,
  output logic       o_align_error
);

  localparam logic [2:0] LP_ONES_LAST = 3'(STUFF_LEN - 1);

  logic       r_prev_line;
  logic [2:0] r_ones_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_stuff_pending;
  logic [7:0] r_shreg;
  logic       r_d_orig;
  logic [7:0] r_rx_byte;
  logic       r_byte_valid;
  logic       r_stuff_error;
  logic       r_align_error;

  logic       w_decoded;
  logic [7:0] w_next_shreg;

  // A line level equal to the previous one decodes as 1, a transition as 0.
  assign w_decoded    = ~(i_d_plus_sync ^ r_prev_line);
  assign w_next_shreg = {w_decoded, r_shreg[7:1]};

  assign o_invalid_bit = r_stuff_pending & i_shift_enable;
  assign o_d_orig      = r_d_orig;
  assign o_rx_byte     = r_rx_byte;
  assign o_byte_valid  = r_byte_valid;
  assign o_stuff_error = r_stuff_error;
  assign o_align_error = r_align_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_line     <= IDLE_LEVEL;
      r_ones_cnt      <= 3'd0;
      r_bit_cnt       <= 3'd0;
      r_stuff_pending <= 1'b0;
      r_shreg         <= 8'h00;
      r_d_orig        <= 1'b1;
      r_rx_byte       <= 8'h00;
      r_byte_valid    <= 1'b0;
      r_stuff_error   <= 1'b0;
      r_align_error   <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_stuff_error <= 1'b0;
      r_align_error <= 1'b0;

      if (i_eop_detected) begin
        r_prev_line     <= IDLE_LEVEL;
        r_ones_cnt      <= 3'd0;
        r_bit_cnt       <= 3'd0;
        r_stuff_pending <= 1'b0;
        r_align_error   <= (r_bit_cnt != 3'd0);
      end else if (!i_rcv_active) begin
        r_prev_line     <= IDLE_LEVEL;
        r_ones_cnt      <= 3'd0;
        r_bit_cnt       <= 3'd0;
        r_stuff_pending <= 1'b0;
      end else if (i_shift_enable) begin
        r_prev_line <= i_d_plus_sync;
        r_d_orig    <= w_decoded;

        if (r_stuff_pending) begin
          // Stuff bit: discarded; it must have been a transition (decoded 0).
          r_stuff_pending <= 1'b0;
          r_ones_cnt      <= 3'd0;
          r_stuff_error   <= w_decoded;
        end else begin
          r_shreg   <= w_next_shreg;
          r_bit_cnt <= r_bit_cnt + 3'd1;

          if (w_decoded) begin
            if (r_ones_cnt == LP_ONES_LAST) begin
              r_stuff_pending <= 1'b1;
              r_ones_cnt      <= 3'd0;
            end else begin
              r_ones_cnt <= r_ones_cnt + 3'd1;
            end
          end else begin
            r_ones_cnt <= 3'd0;
          end

          if (r_bit_cnt == 3'd7) begin
            r_rx_byte    <= w_next_shreg;
            r_byte_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// tb/tb_rx_nrzi_unstuff.sv - scoreboard bench for rx_nrzi_unstuff
module tb_rx_nrzi_unstuff;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_plus;
  logic       shift_en;
  logic       rcv;
  logic       eop;
  logic       d_orig;
  logic       invalid_bit;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stuff_error;
  logic       align_error;

  rx_nrzi_unstuff #(.STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_d_plus_sync  (d_plus),
    .i_shift_enable (shift_en),
    .i_rcv_active   (rcv),
    .i_eop_detected (eop),
    .o_d_orig       (d_orig),
    .o_invalid_bit  (invalid_bit),
    .o_rx_byte      (rx_byte),
    .o_byte_valid   (byte_valid),
    .o_stuff_error  (stuff_error),
    .o_align_error  (align_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_stuff_err = 0;
  int   n_align_err = 0;
  logic tb_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected byte per byte_valid and checks data and cycle.
  always @(negedge clk) begin
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.b});
        chk("byte_valid_cycle", cyc, e.c);
      end
    end
    if (stuff_error) n_stuff_err++;
    if (align_error) n_align_err++;
  end

  task automatic strobe(input logic d, input logic exp_inv, input bit push, input logic [7:0] b);
    d_plus   = d;
    shift_en = 1'b1;
    tb_prev  = d;
    @(negedge clk);
    chk("invalid_bit", {31'd0, invalid_bit}, {31'd0, exp_inv});
    if (push) exp_q.push_back('{b, cyc + 1});
    @(posedge clk);
    #1;
    shift_en = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit complete);
    for (int i = 0; i < n; i++) begin
      logic lvl;
      lvl = b[i] ? tb_prev : ~tb_prev;
      strobe(lvl, 1'b0, complete && (i == n - 1), b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drop_rcv();
    rcv = 1'b0;
    @(posedge clk);
    #1;
    rcv     = 1'b1;
    tb_prev = 1'b1;
  endtask

  task automatic reset_and_check();
    rst      = 1'b1;
    shift_en = 1'b1;
    d_plus   = ~tb_prev;
    @(posedge clk);
    @(negedge clk);
    chk("rst_d_orig", {31'd0, d_orig}, 32'd1);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'h00);
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_stuff_error", {31'd0, stuff_error}, 32'd0);
    chk("rst_align_error", {31'd0, align_error}, 32'd0);
    chk("rst_invalid_bit", {31'd0, invalid_bit}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    shift_en = 1'b0;
    tb_prev  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; d_plus = 1'b1; shift_en = 1'b0; rcv = 1'b0; eop = 1'b0;
    idle(1);
    reset_and_check();
    rcv = 1'b1;

    // SYNC pattern decodes to 0x80
    strobe(1'b0, 1'b0, 0, 8'h00);
    strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 0, 8'h00);
    strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 0, 8'h00);
    strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 1, 8'h80);
    idle(2);

    // Reset mid-byte (last decoded bit 0), then a clean byte from bit 0
    send_bits(8'h5A, 3, 0);
    reset_and_check();
    send_bits(8'h3C, 8, 1);
    idle(2);

    // Stuffing: six 1s, stuff bit, then D+ 0,0 -> decoded 1,1
    drop_rcv();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b1, 0, 8'h00);
    strobe(1'b0, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 1, 8'hFF);
    idle(2);
    chk("no_stuff_error_clean_stuff", n_stuff_err, 32'd0);

    // Stuffing: six 1s, stuff bit, then D+ 1,0 -> decoded 0,0
    drop_rcv();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b1, 0, 8'h00);
    strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b0, 1'b0, 1, 8'h3F);
    idle(2);

    // Stuff error: stuff position holds a 1; two more 1s finish the byte without a new stuff
    drop_rcv();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b1, 1'b1, 0, 8'h00);
    idle(2);
    chk("stuff_error_pulse", n_stuff_err, 32'd1);
    strobe(1'b1, 1'b0, 0, 8'h00);
    strobe(1'b1, 1'b0, 1, 8'hFF);
    idle(2);

    // EOP after 3 data bits
    drop_rcv();
    send_bits(8'h5A, 3, 0);
    eop = 1'b1;
    @(posedge clk);
    #1;
    eop = 1'b0;
    tb_prev = 1'b1;
    idle(2);
    chk("align_error_pulse", n_align_err, 32'd1);
    send_bits(8'hC3, 8, 1);
    idle(2);

    // Strobe coinciding with EOP is ignored
    send_bits(8'h01, 2, 0);
    d_plus   = tb_prev;
    shift_en = 1'b1;
    eop      = 1'b1;
    @(posedge clk);
    #1;
    shift_en = 1'b0;
    eop      = 1'b0;
    tb_prev  = 1'b1;
    @(negedge clk);
    chk("d_orig_hold_on_eop", {31'd0, d_orig}, 32'd0);
    idle(2);
    chk("align_error_simul", n_align_err, 32'd2);
    send_bits(8'h96, 8, 1);

    idle(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("stuff_error_total", n_stuff_err, 32'd1);
    chk("align_error_total", n_align_err, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
